// File: rtl/rggen_apb_requester.sv
// APB4 initiator: one valid/ready command becomes one APB transfer plus one valid/ready response.
// Latency: accept N, SETUP N+1, ACCESS N+2.., response one cycle after pready or timeout.
// Backpressure: one command outstanding; o_cmd_ready is low from accept until the response is consumed.
module rggen_apb_requester #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_rsp_error,
    output logic                     o_rsp_timeout,
    output logic                     o_psel,
    output logic                     o_penable,
    output logic                     o_pwrite,
    output logic [ADDRESS_WIDTH-1:0] o_paddr,
    output logic [BUS_WIDTH-1:0]     o_pwdata,
    output logic [BUS_WIDTH/8-1:0]   o_pstrb,
    input  logic                     i_pready,
    input  logic                     i_pslverr,
    input  logic [BUS_WIDTH-1:0]     i_prdata
);
    localparam int STRB_WIDTH   = BUS_WIDTH / 8;
    localparam int LSB          = $clog2(STRB_WIDTH);
    localparam int COUNT_WIDTH  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~(ADDRESS_WIDTH'((1 << LSB) - 1));

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETUP    = 2'd1;
    localparam logic [1:0] ACCESS   = 2'd2;
    localparam logic [1:0] RESPONSE = 2'd3;

    logic [1:0]               state;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [STRB_WIDTH-1:0]    strobe;
    logic [BUS_WIDTH-1:0]     read_data;
    logic                     error;
    logic                     timeout;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     timeout_hit;
    logic                     run;
    logic                     bus_active;

    // TIMEOUT_CYCLES == 0 disables the abort path entirely
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == COUNT_WIDTH'(TIMEOUT_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            write      <= 1'b0;
            address    <= '0;
            write_data <= '0;
            strobe     <= '0;
            read_data  <= '0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        write      <= i_cmd_write;
                        address    <= i_cmd_address & ADDR_MASK;
                        write_data <= i_cmd_write_data;
                        strobe     <= i_cmd_write ? i_cmd_strobe : '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    count <= '0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout landing in the same cycle
                    if (i_pready) begin
                        read_data <= write ? '0 : i_prdata;
                        error     <= i_pslverr;
                        timeout   <= 1'b0;
                        state     <= RESPONSE;
                    end else if (timeout_hit) begin
                        read_data <= '0;
                        error     <= 1'b1;
                        timeout   <= 1'b1;
                        state     <= RESPONSE;
                    end else begin
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low combinationally so they read 0 for the whole reset window
    assign run        = !i_rst;
    assign bus_active = run && ((state == SETUP) || (state == ACCESS));

    assign o_cmd_ready     = run && (state == IDLE);
    assign o_psel          = bus_active;
    assign o_penable       = run && (state == ACCESS);
    assign o_pwrite        = bus_active && write;
    assign o_paddr         = bus_active ? address : '0;
    assign o_pwdata        = bus_active ? write_data : '0;
    assign o_pstrb         = bus_active ? strobe : '0;
    assign o_rsp_valid     = run && (state == RESPONSE);
    assign o_rsp_read_data = o_rsp_valid ? read_data : '0;
    assign o_rsp_error     = o_rsp_valid && error;
    assign o_rsp_timeout   = o_rsp_valid && timeout;

    a_penable_psel: assert property (@(posedge i_clk) disable iff (i_rst)
        o_penable |-> o_psel);
    a_apb_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        o_penable |-> ($past(o_psel) && $stable({o_paddr, o_pwrite, o_pwdata, o_pstrb})));
    a_no_psel_in_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
        o_rsp_valid |-> !o_psel);
endmodule

// File: tb/tb_rggen_apb_requester.sv
// Randomized bench for rggen_apb_requester: a per-transfer reference model predicts
// every phase cycle-by-cycle from wait count, slave error and response backpressure.
module tb_rggen_apb_requester;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int SW = BW / 8;
    localparam int T  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [BW-1:0] cmd_write_data;
    logic [SW-1:0] cmd_strobe;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [BW-1:0] rsp_read_data;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready;
    logic          pslverr;
    logic [BW-1:0] prdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rggen_apb_requester #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_write     (cmd_write),
        .i_cmd_address   (cmd_address),
        .i_cmd_write_data(cmd_write_data),
        .i_cmd_strobe    (cmd_strobe),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_read_data (rsp_read_data),
        .o_rsp_error     (rsp_error),
        .o_rsp_timeout   (rsp_timeout),
        .o_psel          (psel),
        .o_penable       (penable),
        .o_pwrite        (pwrite),
        .o_paddr         (paddr),
        .o_pwdata        (pwdata),
        .o_pstrb         (pstrb),
        .i_pready        (pready),
        .i_pslverr       (pslverr),
        .i_prdata        (prdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_error, rsp_timeout, psel, penable, pwrite}, 0);
        check_eq({tag, "_bus"}, {paddr, pstrb, pwdata}, 0);
        check_eq({tag, "_rdata"}, rsp_read_data, 0);
    endtask

    task automatic slave_noise();
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
    endtask

    // One full command: the slave answers after wt ACCESS cycles (no answer if wt >= T),
    // the response sink holds rsp_ready low for hold cycles.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                        input logic [SW-1:0] st, input int wt, input bit serr,
                        input logic [BW-1:0] rd, input int hold);
        bit            tmo;
        int            last;
        logic [AW-1:0] exp_addr;
        logic [SW-1:0] exp_strb;
        logic [BW-1:0] exp_rd;
        bit            exp_err;
        tmo      = (wt > T - 1);
        last     = tmo ? T - 1 : wt;
        exp_addr = addr - (addr % AW'(SW));
        exp_strb = wr ? st : '0;
        exp_rd   = (tmo || wr) ? '0 : rd;
        exp_err  = tmo || serr;

        @(negedge clk);
        check_eq("idle_cmd_ready", cmd_ready, 1);
        check_eq("idle_psel", psel, 0);
        cmd_valid      = 1'b1;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_write_data = wd;
        cmd_strobe     = st;
        slave_noise();

        @(negedge clk);
        cmd_valid      = 1'b0;
        cmd_write      = 1'($urandom);
        cmd_address    = AW'($urandom);
        cmd_write_data = $urandom;
        cmd_strobe     = SW'($urandom);
        check_eq("setup_cmd_ready", cmd_ready, 0);
        check_eq("setup_psel_penable", {psel, penable}, 2'b10);
        check_eq("setup_paddr", paddr, exp_addr);
        check_eq("setup_pwrite", pwrite, wr);
        check_eq("setup_pwdata", pwdata, wd);
        check_eq("setup_pstrb", pstrb, exp_strb);
        check_eq("setup_rsp_valid", rsp_valid, 0);
        slave_noise();

        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            check_eq("access_psel_penable", {psel, penable}, 2'b11);
            check_eq("access_hold", {paddr, pwrite, pwdata, pstrb}, {exp_addr, wr, wd, exp_strb});
            check_eq("access_rsp_valid", rsp_valid, 0);
            pready  = (k == wt);
            pslverr = (k == wt) ? serr : 1'($urandom);
            prdata  = (k == wt) ? rd : $urandom;
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check_eq("rsp_psel_penable", {psel, penable}, 2'b00);
            check_eq("rsp_cmd_ready", cmd_ready, 0);
            check_eq("rsp_valid", rsp_valid, 1);
            check_eq("rsp_read_data", rsp_read_data, exp_rd);
            check_eq("rsp_error_timeout", {rsp_error, rsp_timeout}, {exp_err, tmo});
            slave_noise();
            rsp_ready = (h == hold);
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_rsp_cmd_ready", cmd_ready, 1);
        check_eq("post_rsp_valid", rsp_valid, 0);
    endtask

    task automatic reset_in_access();
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 16'h0040;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        #1;
        check_all_zero("reset_comb");
        @(negedge clk);
        check_all_zero("reset_edge");
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_release_cmd_ready", cmd_ready, 1);
        check_eq("reset_release_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_address    = '0;
        cmd_write_data = '0;
        cmd_strobe     = '0;
        rsp_ready      = 1'b0;
        pready         = 1'b0;
        pslverr        = 1'b0;
        prdata         = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        xfer(1'b1, 16'h0010, 32'hA5A5_00FF, 4'hF, 0, 1'b0, 32'h0, 0);
        xfer(1'b0, 16'h0013, 32'hDEAD_BEEF, 4'hA, 5, 1'b0, 32'h1234_5678, 0);
        xfer(1'b0, 16'h0022, 32'h0, 4'h0, 2, 1'b1, 32'h1234_5678, 0);
        xfer(1'b0, 16'h0030, 32'h0, 4'h0, 50, 1'b0, 32'h1234_5678, 0);
        xfer(1'b1, 16'h0035, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'hFFFF_FFFF, 10);
        reset_in_access();
        xfer(1'b1, 16'h0044, 32'hCAFE_0001, 4'h5, 0, 1'b0, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                 $urandom_range(0, T + 2), 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
